fft_unscramble: RTL and testbench
=================================

# fft_unscramble

Streaming reorder buffer that accepts frames of 2^LOG2N samples in bit-reversed index order and emits them in natural order. It sits directly after the radix-2 FFT core, which produces bit-reversed output, and feeds the spectrum/waterfall path. Double-buffered (ping-pong) so one frame fills while the previous one drains, sustaining one sample per clock.

## Interface
- WIDTH, 32: sample width in bits.
- LOG2N, 10: log2 of frame length N; legal 2..12.
- clk  input  1  clock; all logic rising-edge.
- rst_n  input  1  asynchronous active-low reset.
- in_valid  input  1  input sample present.
- in_data  input  WIDTH  input sample; k-th accepted sample of a frame has natural index bitrev(k).
- in_ready  output  1  buffer can accept in_data this cycle.
- out_valid  output  1  out_data holds a valid sample.
- out_data  output  WIDTH  sample in natural order.
- out_ready  input  1  downstream accepts out_data this cycle.
- out_last  output  1  qualifies out_data as natural index N-1.
- out_index  output  LOG2N  natural index of out_data; present only with FFT_UNSCRAMBLE_INDEX_EN.

## Operation
- Storage: two banks, each N x WIDTH, synchronous-read RAM (inferred block RAM).
- Per-bank full flag. Write side: wbank, wcnt[LOG2N-1:0]. Read side: rbank, rcnt[LOG2N-1:0].
- Write: in_ready = !full[wbank]. On in_valid && in_ready: RAM[wbank][bitrev(wcnt)] <= in_data; wcnt++. When wcnt == N-1 on accept: wcnt wraps to 0, full[wbank] set, wbank toggles.
- Read issue: rd_en = full[rbank] && (!out_valid || out_ready). On rd_en: read RAM[rbank][rcnt]; rcnt++. When rcnt == N-1 on issue: rcnt wraps to 0, full[rbank] cleared, rbank toggles.
- Output register: on rd_en, out_valid <= 1 next cycle, out_last <= (rcnt == N-1), out_index <= rcnt. On out_ready && out_valid && !rd_en: out_valid <= 0. While out_valid && !out_ready, out_data/out_last/out_index are held stable (RAM read enable gated).
- Frames are strictly sequential; no frame-start input. Sample count alone defines frame boundaries.
- bitrev(k): bit i of address = bit LOG2N-1-i of k; pure wiring.

## Timing
- Reset values: in_ready 1, out_valid 0, out_last 0, out_data 0, out_index 0; full flags, counters, bank selects 0.
- Reset mid-frame: any partial or full frame discarded; first accepted sample after reset is index-0 position of a new frame.
- Latency: last sample of a frame accepted at edge T; full set at T; read issued in cycle after T; out_valid high after edge T+1 (2 cycles input-last to first output).
- Throughput: 1 sample/clk both sides in steady state with out_ready held high.
- Both banks full: in_ready 0 until drain of the older bank issues its last read; in_ready returns the cycle after that issue edge.
- Simultaneous last-write to bank A and last-read from bank B in one cycle: both flag updates take effect; no conflict, banks differ.
- Write and read never address the same bank in the same cycle (full flag interlock).
- out_ready deasserted mid-frame: drain pauses, no sample lost or duplicated.

## Configuration
- FFT_UNSCRAMBLE_INDEX_EN defined: out_index port present, driven as above.
- Undefined: out_index port and its register absent; all other behaviour identical.

## Test plan
- LOG2N=3, feed 0,4,2,6,1,5,3,7 back-to-back, out_ready=1 -> out_data 0..7 in order, out_last only on 7, first out_valid 2 cycles after last input.
- Three consecutive frames (LOG2N=3) continuous, out_ready=1 -> 24 outputs in order, in_ready never drops.
- out_ready=0 while filling two frames -> in_ready falls after 16th accept; raise out_ready -> in_ready returns one cycle after 8th output read issue.
- Random out_ready toggling (50%) over 5 frames of LOG2N=4 -> output stream equals natural order, data held stable while stalled.
- Assert rst_n low after 5 samples of frame, then feed a full frame -> only new frame emitted, no stale data; all outputs at reset values during reset.
- With FFT_UNSCRAMBLE_INDEX_EN: out_index equals out_data for test-1 stimulus; without macro, build has no out_index port.

Source files
------------

// File: rtl/fft_unscramble.sv
// fft_unscramble
// ----------------------------------------------------------------------------
// Streaming reorder buffer that sits behind the radix-2 FFT core. Frames of
// N = 2**LOG2N samples arrive in bit-reversed index order and leave in natural
// index order. Two N-entry banks work as a ping-pong pair: one bank fills while
// the other drains, so both sides can run at one sample per clock.
//
// Parameters
//   WIDTH      sample width in bits
//   LOG2N      log2 of the frame length (legal 2..12)
//
// Ports
//   clk        rising-edge clock
//   rst_n      asynchronous active-low reset; discards any partial/full frames
//   in_valid   input sample present
//   in_data    input sample; k-th accepted sample of a frame has natural
//              index bitrev(k)
//   in_ready   buffer can take in_data this cycle
//   out_valid  out_data holds a sample
//   out_data   sample in natural order
//   out_ready  downstream takes out_data this cycle
//   out_last   out_data is natural index N-1
//   out_index  natural index of out_data (only with FFT_UNSCRAMBLE_INDEX_EN)
//
// Handshake: on both sides a transfer happens on a rising edge where valid and
// ready are both high. in_ready depends only on internal state, never on
// in_valid. Once out_valid is high, out_data/out_last/out_index stay stable
// until the cycle out_ready is seen high.
//
// Configuration macro: FFT_UNSCRAMBLE_INDEX_EN adds the out_index port.
// ----------------------------------------------------------------------------
module fft_unscramble #(
  parameter int WIDTH = 32,
  parameter int LOG2N = 10
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  input  logic [WIDTH-1:0] in_data,
  output logic             in_ready,
  output logic             out_valid,
  output logic [WIDTH-1:0] out_data,
  input  logic             out_ready,
  output logic             out_last
`ifdef FFT_UNSCRAMBLE_INDEX_EN
  ,
  output logic [LOG2N-1:0] out_index
`endif
);

  localparam int N = 1 << LOG2N;
  localparam logic [LOG2N-1:0] CNT_LAST = '1;

  // Both banks live in one array; the bank select is the top address bit.
  logic [WIDTH-1:0] mem [0:2*N-1];

  logic [1:0]       full;
  logic             wbank;
  logic             rbank;
  logic [LOG2N-1:0] wcnt;
  logic [LOG2N-1:0] rcnt;
  logic [LOG2N-1:0] wrev;
  logic             wr_en;
  logic             rd_en;

  // Bit-reversed write address: pure wiring.
  for (genvar i = 0; i < LOG2N; i++) begin : g_bitrev
    assign wrev[i] = wcnt[LOG2N-1-i];
  end

  assign in_ready = !full[wbank];
  assign wr_en    = in_valid && in_ready;
  // Reads issue only when the output register is empty or being emptied,
  // which also keeps the read data stable during a stall.
  assign rd_en    = full[rbank] && (!out_valid || out_ready);

  always_ff @(posedge clk) begin
    if (wr_en) begin
      mem[{wbank, wrev}] <= in_data;
    end
  end

  // Bank bookkeeping. A writable bank is never full and a readable bank is
  // always full, so the set and clear below can never target the same bank.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      full  <= '0;
      wbank <= 1'b0;
      rbank <= 1'b0;
      wcnt  <= '0;
      rcnt  <= '0;
    end else begin
      if (wr_en) begin
        wcnt <= wcnt + 1'b1;
        if (wcnt == CNT_LAST) begin
          full[wbank] <= 1'b1;
          wbank       <= !wbank;
        end
      end
      if (rd_en) begin
        rcnt <= rcnt + 1'b1;
        if (rcnt == CNT_LAST) begin
          full[rbank] <= 1'b0;
          rbank       <= !rbank;
        end
      end
    end
  end

  // Output register doubles as the synchronous RAM read register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      out_valid <= 1'b0;
      out_data  <= '0;
      out_last  <= 1'b0;
`ifdef FFT_UNSCRAMBLE_INDEX_EN
      out_index <= '0;
`endif
    end else if (rd_en) begin
      out_valid <= 1'b1;
      out_data  <= mem[{rbank, rcnt}];
      out_last  <= (rcnt == CNT_LAST);
`ifdef FFT_UNSCRAMBLE_INDEX_EN
      out_index <= rcnt;
`endif
    end else if (out_ready) begin
      out_valid <= 1'b0;
    end
  end

endmodule

// File: tb/tb_fft_unscramble.sv
// Testbench for fft_unscramble with WIDTH=16, LOG2N=3 (N=8).
// Frames are built in natural order by a reference model, fed in bit-reversed
// order, and the natural-order stream is expected back.
module tb_fft_unscramble;

  localparam int W = 16;
  localparam int L = 3;
  localparam int N = 1 << L;

  logic         clk = 1'b0;
  logic         rst_n = 1'b0;
  logic         in_valid = 1'b0;
  logic [W-1:0] in_data = '0;
  logic         out_ready = 1'b0;
  logic         in_ready;
  logic         out_valid;
  logic [W-1:0] out_data;
  logic         out_last;
`ifdef FFT_UNSCRAMBLE_INDEX_EN
  logic [L-1:0] out_index;
`endif

  int checks = 0;
  int passes = 0;
  int cyc = 0;

  logic [W-1:0] src_q[$];
  logic [W-1:0] exp_q[$];
  logic [W-1:0] got_q[$];
  bit           got_last_q[$];
  logic [L-1:0] got_idx_q[$];

  fft_unscramble #(.WIDTH(W), .LOG2N(L)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_valid  (in_valid),
    .in_data   (in_data),
    .in_ready  (in_ready),
    .out_valid (out_valid),
    .out_data  (out_data),
    .out_ready (out_ready),
    .out_last  (out_last)
`ifdef FFT_UNSCRAMBLE_INDEX_EN
    ,
    .out_index (out_index)
`endif
  );

  // ---------------- clock / reset ----------------
  always #5 clk = ~clk;

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  task automatic clear_queues();
    src_q.delete();
    exp_q.delete();
    got_q.delete();
    got_last_q.delete();
    got_idx_q.delete();
  endtask

  // ---------------- reference model ----------------
  function automatic int bitrev_ref(int k);
    int r = 0;
    for (int b = 0; b < L; b++) r = (r << 1) | ((k >> b) & 1);
    return r;
  endfunction

  // One frame: natural-order values go to exp_q, bit-reversed feed to src_q.
  task automatic gen_frame(input bit ramp);
    logic [W-1:0] nat[N];
    for (int j = 0; j < N; j++)
      nat[j] = ramp ? W'(j) : W'($urandom_range(0, 65535));
    for (int j = 0; j < N; j++) exp_q.push_back(nat[j]);
    for (int k = 0; k < N; k++) src_q.push_back(nat[bitrev_ref(k)]);
  endtask

  // ---------------- driver ----------------
  // Sets inputs at the falling edge and records what the next rising edge
  // will transfer on each side.
  task automatic drive_cycle(input bit iv, input bit ordy, output bit acc,
                             output bit ov, output logic [W-1:0] od, output bit ir);
    @(negedge clk);
    in_valid  = iv && (src_q.size() > 0);
    in_data   = (src_q.size() > 0) ? src_q[0] : '0;
    out_ready = ordy;
    ir  = in_ready;
    ov  = out_valid;
    od  = out_data;
    acc = in_valid && in_ready;
    if (acc) void'(src_q.pop_front());
    if (out_valid && ordy) begin
      got_q.push_back(out_data);
      got_last_q.push_back(out_last);
`ifdef FFT_UNSCRAMBLE_INDEX_EN
      got_idx_q.push_back(out_index);
`endif
    end
    cyc++;
  endtask

  // ---------------- tests ----------------
  task automatic test_reset();
    @(negedge clk);
    rst_n = 1'b0;
    #1;
    checks++; if (in_ready !== 1'b1) $display("FAIL reset_in_ready got %b exp 1", in_ready); else passes++;
    checks++; if (out_valid !== 1'b0) $display("FAIL reset_out_valid got %b exp 0", out_valid); else passes++;
    checks++; if (out_last !== 1'b0) $display("FAIL reset_out_last got %b exp 0", out_last); else passes++;
    checks++; if (out_data !== '0) $display("FAIL reset_out_data got %h exp 0", out_data); else passes++;
`ifdef FFT_UNSCRAMBLE_INDEX_EN
    checks++; if (out_index !== '0) $display("FAIL reset_out_index got %0d exp 0", out_index); else passes++;
`endif
    @(negedge clk);
    rst_n = 1'b1;
    clear_queues();
  endtask

  task automatic test_single_frame();
    bit acc, ov, ir;
    logic [W-1:0] od;
    int last_acc = -100, first_ov = -1, budget = 60;
    clear_queues();
    gen_frame(1'b1);  // feed is 0,4,2,6,1,5,3,7
    while ((src_q.size() > 0 || got_q.size() < N) && budget > 0) begin
      drive_cycle(1'b1, 1'b1, acc, ov, od, ir);
      if (acc && src_q.size() == 0) last_acc = cyc;
      if (ov && first_ov < 0) first_ov = cyc;
      budget--;
    end
    checks++; if (first_ov - last_acc !== 2)
      $display("FAIL single_latency got %0d exp 2", first_ov - last_acc); else passes++;
    checks++; if (got_q.size() !== exp_q.size())
      $display("FAIL single_count got %0d exp %0d", got_q.size(), exp_q.size()); else passes++;
    for (int i = 0; i < exp_q.size() && i < got_q.size(); i++) begin
      checks++; if (got_q[i] !== exp_q[i])
        $display("FAIL single_data[%0d] got %h exp %h", i, got_q[i], exp_q[i]); else passes++;
      checks++; if (got_last_q[i] !== ((i % N) == N - 1))
        $display("FAIL single_last[%0d] got %b exp %b", i, got_last_q[i], (i % N) == N - 1); else passes++;
`ifdef FFT_UNSCRAMBLE_INDEX_EN
      checks++; if (W'(got_idx_q[i]) !== got_q[i])
        $display("FAIL single_index[%0d] got %0d exp %0d", i, got_idx_q[i], got_q[i]); else passes++;
`endif
    end
    repeat (3) drive_cycle(1'b0, 1'b1, acc, ov, od, ir);
  endtask

  task automatic test_back_to_back();
    bit acc, ov, ir;
    logic [W-1:0] od;
    int drops = 0, first_acc = -1, last_acc = -1, budget = 200;
    clear_queues();
    repeat (3) gen_frame(1'b0);
    while ((src_q.size() > 0 || got_q.size() < 3 * N) && budget > 0) begin
      bit feeding = src_q.size() > 0;
      drive_cycle(1'b1, 1'b1, acc, ov, od, ir);
      if (feeding && !ir) drops++;
      if (acc && first_acc < 0) first_acc = cyc;
      if (acc) last_acc = cyc;
      budget--;
    end
    checks++; if (drops !== 0) $display("FAIL b2b_in_ready_drops got %0d exp 0", drops); else passes++;
    checks++; if (last_acc - first_acc !== 3 * N - 1)
      $display("FAIL b2b_accept_span got %0d exp %0d", last_acc - first_acc, 3 * N - 1); else passes++;
    checks++; if (got_q.size() !== exp_q.size())
      $display("FAIL b2b_count got %0d exp %0d", got_q.size(), exp_q.size()); else passes++;
    for (int i = 0; i < exp_q.size() && i < got_q.size(); i++) begin
      checks++; if (got_q[i] !== exp_q[i])
        $display("FAIL b2b_data[%0d] got %h exp %h", i, got_q[i], exp_q[i]); else passes++;
      checks++; if (got_last_q[i] !== ((i % N) == N - 1))
        $display("FAIL b2b_last[%0d] got %b exp %b", i, got_last_q[i], (i % N) == N - 1); else passes++;
`ifdef FFT_UNSCRAMBLE_INDEX_EN
      checks++; if (got_idx_q[i] !== L'(i % N))
        $display("FAIL b2b_index[%0d] got %0d exp %0d", i, got_idx_q[i], i % N); else passes++;
`endif
    end
    repeat (3) drive_cycle(1'b0, 1'b1, acc, ov, od, ir);
  endtask

  task automatic test_backpressure();
    bit acc, ov, ir;
    logic [W-1:0] od;
    int n_acc = 0, zero_cnt = 0, budget;
    clear_queues();
    repeat (2) gen_frame(1'b0);
    for (int c = 0; c < 2 * N + 4; c++) begin
      drive_cycle(1'b1, 1'b0, acc, ov, od, ir);
      if (acc) n_acc++;
    end
    checks++; if (n_acc !== 2 * N) $display("FAIL bp_accepts got %0d exp %0d", n_acc, 2 * N); else passes++;
    checks++; if (ir !== 1'b0) $display("FAIL bp_in_ready_low got %b exp 0", ir); else passes++;
    checks++; if (ov !== 1'b1 || od !== exp_q[0])
      $display("FAIL bp_held_head got %b/%h exp 1/%h", ov, od, exp_q[0]); else passes++;
    // Raise out_ready; count cycles with in_ready still low.
    budget = 30;
    while (budget > 0) begin
      drive_cycle(1'b0, 1'b1, acc, ov, od, ir);
      if (ir) break;
      zero_cnt++;
      budget--;
    end
    checks++; if (zero_cnt !== N - 1)
      $display("FAIL bp_in_ready_return got %0d exp %0d", zero_cnt, N - 1); else passes++;
    budget = 60;
    while (got_q.size() < 2 * N && budget > 0) begin
      drive_cycle(1'b0, 1'b1, acc, ov, od, ir);
      budget--;
    end
    checks++; if (got_q.size() !== exp_q.size())
      $display("FAIL bp_count got %0d exp %0d", got_q.size(), exp_q.size()); else passes++;
    for (int i = 0; i < exp_q.size() && i < got_q.size(); i++) begin
      checks++; if (got_q[i] !== exp_q[i])
        $display("FAIL bp_data[%0d] got %h exp %h", i, got_q[i], exp_q[i]); else passes++;
      checks++; if (got_last_q[i] !== ((i % N) == N - 1))
        $display("FAIL bp_last[%0d] got %b exp %b", i, got_last_q[i], (i % N) == N - 1); else passes++;
    end
    repeat (3) drive_cycle(1'b0, 1'b1, acc, ov, od, ir);
  endtask

  task automatic test_random_stall();
    bit acc, ov, ir, ordy, prev_stall = 1'b0;
    logic [W-1:0] od, prev_od = '0;
    int budget = 3000;
    clear_queues();
    repeat (5) gen_frame(1'b0);
    while ((src_q.size() > 0 || got_q.size() < 5 * N) && budget > 0) begin
      ordy = 1'($urandom_range(0, 1));
      drive_cycle($urandom_range(0, 3) != 0, ordy, acc, ov, od, ir);
      if (prev_stall) begin
        checks++; if (ov !== 1'b1 || od !== prev_od)
          $display("FAIL stall_hold got %b/%h exp 1/%h", ov, od, prev_od); else passes++;
      end
      prev_stall = ov && !ordy;
      prev_od = od;
      budget--;
    end
    checks++; if (got_q.size() !== exp_q.size())
      $display("FAIL rand_count got %0d exp %0d", got_q.size(), exp_q.size()); else passes++;
    for (int i = 0; i < exp_q.size() && i < got_q.size(); i++) begin
      checks++; if (got_q[i] !== exp_q[i])
        $display("FAIL rand_data[%0d] got %h exp %h", i, got_q[i], exp_q[i]); else passes++;
      checks++; if (got_last_q[i] !== ((i % N) == N - 1))
        $display("FAIL rand_last[%0d] got %b exp %b", i, got_last_q[i], (i % N) == N - 1); else passes++;
    end
    repeat (3) drive_cycle(1'b0, 1'b1, acc, ov, od, ir);
  endtask

  task automatic test_reset_midframe();
    bit acc, ov, ir;
    logic [W-1:0] od;
    int n_acc = 0, budget = 100;
    clear_queues();
    // One full frame plus 5 samples of the next, nothing drained.
    repeat (2) gen_frame(1'b0);
    while (n_acc < N + 5 && budget > 0) begin
      drive_cycle(1'b1, 1'b0, acc, ov, od, ir);
      if (acc) n_acc++;
      budget--;
    end
    drive_cycle(1'b0, 1'b0, acc, ov, od, ir);
    checks++; if (ov !== 1'b1) $display("FAIL mid_pre_valid got %b exp 1", ov); else passes++;
    @(negedge clk);
    rst_n = 1'b0;
    in_valid = 1'b0;
    out_ready = 1'b0;
    #1;
    checks++; if (in_ready !== 1'b1) $display("FAIL mid_rst_in_ready got %b exp 1", in_ready); else passes++;
    checks++; if (out_valid !== 1'b0) $display("FAIL mid_rst_out_valid got %b exp 0", out_valid); else passes++;
    checks++; if (out_last !== 1'b0) $display("FAIL mid_rst_out_last got %b exp 0", out_last); else passes++;
    checks++; if (out_data !== '0) $display("FAIL mid_rst_out_data got %h exp 0", out_data); else passes++;
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    clear_queues();
    gen_frame(1'b0);
    budget = 100;
    while ((src_q.size() > 0 || got_q.size() < N) && budget > 0) begin
      drive_cycle(1'b1, 1'b1, acc, ov, od, ir);
      budget--;
    end
    repeat (12) drive_cycle(1'b0, 1'b1, acc, ov, od, ir);
    checks++; if (got_q.size() !== exp_q.size())
      $display("FAIL mid_count got %0d exp %0d", got_q.size(), exp_q.size()); else passes++;
    for (int i = 0; i < exp_q.size() && i < got_q.size(); i++) begin
      checks++; if (got_q[i] !== exp_q[i])
        $display("FAIL mid_data[%0d] got %h exp %h", i, got_q[i], exp_q[i]); else passes++;
      checks++; if (got_last_q[i] !== ((i % N) == N - 1))
        $display("FAIL mid_last[%0d] got %b exp %b", i, got_last_q[i], (i % N) == N - 1); else passes++;
    end
  endtask

  // ---------------- sequence / report ----------------
  initial begin
    rst_n = 1'b0;
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    test_reset();
    test_single_frame();
    test_back_to_back();
    test_backpressure();
    test_random_stall();
    test_reset_midframe();
    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end

endmodule
